addsub_seq_ctrl: RTL and testbench

ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

---
 rtl/addsub_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq_ctrl.sv
// Sequential 16-bit add/subtract built from one 4-bit carry-lookahead slice,
// reused over four cycles (LS nibble first), with optional saturation and Z/V/N flags.
module addsub_seq_ctrl #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [11:0] acc_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] result_q;
  logic        z_q;
  logic        v_q;
  logic        n_q;

  logic [3:0]  sliceA;
  logic [3:0]  sliceB;
  logic [3:0]  gen;
  logic [3:0]  prop;
  logic [3:0]  c;
  logic [3:0]  sliceSum;
  logic        groupG;
  logic        groupP;
  logic        carry_d;
  logic [15:0] sum_d;
  logic        ovf_d;
  logic [15:0] final_d;

  // b_q already holds the inverted operand for subtraction, so the slice only ever adds.
  always_comb begin
    sliceA = a_q[3:0];
    sliceB = b_q[3:0];
    case (idx_q)
      2'd1: begin
        sliceA = a_q[7:4];
        sliceB = b_q[7:4];
      end
      2'd2: begin
        sliceA = a_q[11:8];
        sliceB = b_q[11:8];
      end
      2'd3: begin
        sliceA = a_q[15:12];
        sliceB = b_q[15:12];
      end
      default: ;
    endcase

    gen      = sliceA & sliceB;
    prop     = sliceA ^ sliceB;
    c[0]     = carry_q;
    c[1]     = gen[0] | (prop[0] & c[0]);
    c[2]     = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c[0]);
    c[3]     = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & c[0]);
    sliceSum = prop ^ c;
    groupG   = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
    groupP   = &prop;
    carry_d  = groupG | (groupP & carry_q);

    sum_d    = {sliceSum, acc_q};
    ovf_d    = (a_q[15] == b_q[15]) & (sum_d[15] != a_q[15]);
    final_d  = sum_d;
    if (SATURATE && ovf_d) begin
      final_d = a_q[15] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      carry_q  <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      acc_q    <= 12'h000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub;
            idx_q   <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          carry_q <= carry_d;
          idx_q   <= idx_q + 2'd1;
          case (idx_q)
            2'd0: acc_q[3:0]  <= sliceSum;
            2'd1: acc_q[7:4]  <= sliceSum;
            2'd2: acc_q[11:8] <= sliceSum;
            default: begin
              // Final nibble: publish the result and flags in one shot.
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= final_d;
              z_q      <= (final_d == 16'h0000);
              v_q      <= ovf_d;
              n_q      <= final_d[15];
            end
          endcase
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_z = z_q;
  assign flag_v = v_q;
  assign flag_n = n_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench: two DUTs (saturating and wrapping) against an arithmetic
// reference model, plus directed literal scenarios and a randomized phase.
module tb_addsub_seq_ctrl;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        v;
    logic        n;
  } opRes_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy1, done1, z1, v1, n1;
  logic [15:0] result1;
  logic        busy0, done0, z0, v0, n0;
  logic [15:0] result0;

  int errors = 0;
  int checks = 0;

  addsub_seq_ctrl #(.SATURATE(1'b1)) dutSat (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1),
    .flag_z(z1), .flag_v(v1), .flag_n(n1)
  );

  addsub_seq_ctrl #(.SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(result0),
    .flag_z(z0), .flag_v(v0), .flag_n(n0)
  );

  always #5 clk = ~clk;

  // True signed arithmetic decides overflow; the wrapped sum is its low 16 bits.
  function automatic opRes_t computeOp(input logic [15:0] av, input logic [15:0] bv,
                                       input logic sub, input bit sat);
    opRes_t o;
    int sa;
    int sb;
    int r;
    sa = $signed(av);
    sb = $signed(bv);
    r = sub ? (sa - sb) : (sa + sb);
    o.v = (r > 32767) || (r < -32768);
    o.res = r[15:0];
    if (sat && o.v) o.res = av[15] ? 16'h8000 : 16'h7FFF;
    o.z = (o.res == 16'h0000);
    o.n = o.res[15];
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: an accepted request occupies four busy cycles, then its
  // result appears for one done cycle. Requests during busy cycles are dropped.
  int     remaining = 0;
  bit     modelValid = 1'b0;
  logic   expBusy = 1'b0;
  logic   expDone = 1'b0;
  opRes_t exp1 = '0;
  opRes_t exp0 = '0;
  opRes_t pend1 = '0;
  opRes_t pend0 = '0;

  always @(posedge clk) begin
    modelValid <= 1'b1;
    if (!rst_n) begin
      remaining <= 0;
      expBusy   <= 1'b0;
      expDone   <= 1'b0;
      exp1      <= '0;
      exp0      <= '0;
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
      expBusy   <= (remaining > 1);
      expDone   <= (remaining == 1);
      if (remaining == 1) begin
        exp1 <= pend1;
        exp0 <= pend0;
      end
    end else begin
      expDone <= 1'b0;
      if (start) begin
        remaining <= 4;
        expBusy   <= 1'b1;
        pend1     <= computeOp(a, b, op_sub, 1'b1);
        pend0     <= computeOp(a, b, op_sub, 1'b0);
      end else begin
        expBusy <= 1'b0;
      end
    end
  end

  // Every cycle, both DUTs must match the model; done must never repeat back-to-back.
  logic prevDone1 = 1'b0;
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("busySat",   {15'b0, busy1}, {15'b0, expBusy});
      checkOutput("doneSat",   {15'b0, done1}, {15'b0, expDone});
      checkOutput("resultSat", result1,        exp1.res);
      checkOutput("zSat",      {15'b0, z1},    {15'b0, exp1.z});
      checkOutput("vSat",      {15'b0, v1},    {15'b0, exp1.v});
      checkOutput("nSat",      {15'b0, n1},    {15'b0, exp1.n});
      checkOutput("busyWrap",   {15'b0, busy0}, {15'b0, expBusy});
      checkOutput("doneWrap",   {15'b0, done0}, {15'b0, expDone});
      checkOutput("resultWrap", result0,        exp0.res);
      checkOutput("zWrap",      {15'b0, z0},    {15'b0, exp0.z});
      checkOutput("vWrap",      {15'b0, v0},    {15'b0, exp0.v});
      checkOutput("nWrap",      {15'b0, n0},    {15'b0, exp0.n});
      checkOutput("doneConsecutive", {15'b0, prevDone1 & done1}, 16'h0000);
      prevDone1 <= done1;
    end
  end

  // One-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic sub);
    start  = 1'b1;
    a      = av;
    b      = bv;
    op_sub = sub;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("doneSeen", {15'b0, done1}, 16'h0001);
  endtask

  task automatic runDirected(input logic [15:0] av, input logic [15:0] bv, input logic sub,
                             input logic [15:0] res1, input logic ez, input logic ev,
                             input logic en, input logic [15:0] res0, input logic en0);
    int cyc;
    applyStimulus(av, bv, sub);
    checkOutput("litBusyAfterStart", {15'b0, busy1}, 16'h0001);
    waitDone(cyc);
    checkOutput("litLatency", cyc[15:0], 16'd4);
    checkOutput("litBusyAtDone", {15'b0, busy1}, 16'h0000);
    checkOutput("litResultSat", result1, res1);
    checkOutput("litZ", {15'b0, z1}, {15'b0, ez});
    checkOutput("litV", {15'b0, v1}, {15'b0, ev});
    checkOutput("litN", {15'b0, n1}, {15'b0, en});
    checkOutput("litResultWrap", result0, res0);
    checkOutput("litNWrap", {15'b0, n0}, {15'b0, en0});
    @(negedge clk);
    checkOutput("litDoneDrops", {15'b0, done1}, 16'h0000);
  endtask

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int cyc;
    int doneCount;
    rst_n  = 1'b0;
    start  = 1'b1;
    op_sub = 1'b0;
    a      = 16'h1111;
    b      = 16'h2222;
    repeat (2) @(negedge clk);
    checkOutput("resetResult", result1, 16'h0000);
    checkOutput("resetBusy", {15'b0, busy1}, 16'h0000);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    runDirected(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0);
    runDirected(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b1);
    runDirected(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b0);
    runDirected(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Start during CALC with other operands must be ignored.
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    waitDone(cyc);
    checkOutput("ignoredStartResult", result1, 16'h3333);
    doneCount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done1 === 1'b1) doneCount++;
    end
    checkOutput("ignoredStartSingleDone", doneCount[15:0], 16'd0);

    // Reset while nibble 2 is being computed aborts the request.
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abortResult", result1, 16'h0000);
    checkOutput("abortBusy", {15'b0, busy1}, 16'h0000);
    checkOutput("abortDone", {15'b0, done1}, 16'h0000);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done1 === 1'b1) doneCount++;
    end
    checkOutput("abortNoDone", doneCount[15:0], 16'd0);
    runDirected(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0);

    // Back-to-back: start held high through DONE launches the next operation.
    start  = 1'b1;
    a      = 16'h0001;
    b      = 16'h0001;
    op_sub = 1'b0;
    @(negedge clk);
    waitDone(cyc);
    checkOutput("b2bFirstResult", result1, 16'h0002);
    a      = 16'h0003;
    b      = 16'h0004;
    op_sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2bGap", cyc[15:0], 16'd5);
    checkOutput("b2bSecondResult", result1, 16'hFFFF);
    checkOutput("b2bN", {15'b0, n1}, 16'h0001);

    // Randomized traffic, including occasional resets and overflow-prone operands.
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      start  = ($urandom_range(0, 2) == 0);
      op_sub = 1'($urandom_range(0, 1));
      a      = pickOperand();
      b      = pickOperand();
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
